// File: rtl/product_accumulator.sv
// product_accumulator
//    Accumulate stage behind the N-bit multiplier. A job starts with a product
//    count (len), takes that many 2N-bit unsigned products over a valid/ready
//    handshake, and sums them modulo 2^ACC_W. The sum and a sticky overflow
//    flag are then offered over a valid/ready handshake.
//
// Ports
//    clk         clock, rising edge
//    rst         asynchronous reset, active high
//    start, len  job request and product count, sampled only in IDLE
//    prod_valid, prod_ready, product   product input handshake
//    acc_valid, acc_ready, acc_out     result output handshake
//    overflow    sticky carry-out of the accumulator for the current job
//    busy        high whenever the block is not in IDLE
//
// State | meaning
// IDLE  | waiting for start; previous result and overflow remain readable
// ACCUM | accepting products, remaining counts down to the last one
// HOLD  | result presented until acc_ready
module product_accumulator #(
   parameter int N     = 4,
   parameter int ACC_W = 12,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             prod_valid,
   output logic             prod_ready,
   input  logic [2*N-1:0]   product,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t           state;
   logic [LEN_W-1:0] remaining;
   logic [ACC_W:0]   sum_ext;

   // One extra bit captures the carry out of the ACC_W-bit accumulator.
   assign sum_ext = {1'b0, acc_out} + {{(ACC_W + 1 - 2*N){1'b0}}, product};

   // Handshake outputs depend on registered state only.
   assign prod_ready = (state == ACCUM);
   assign acc_valid  = (state == HOLD);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc_out   <= '0;
         overflow  <= 1'b0;
         remaining <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc_out   <= '0;
                  overflow  <= 1'b0;
                  remaining <= len;
                  state     <= (len == '0) ? HOLD : ACCUM;
               end
            end
            ACCUM: begin
               if (prod_valid) begin
                  acc_out   <= sum_ext[ACC_W-1:0];
                  if (sum_ext[ACC_W])
                     overflow <= 1'b1;
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1))
                     state <= HOLD;
               end
            end
            HOLD: begin
               if (acc_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

   localparam int N     = 4;
   localparam int ACC_W = 12;
   localparam int LEN_W = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             prod_valid;
   logic             prod_ready;
   logic [2*N-1:0]   product;
   logic             acc_valid;
   logic             acc_ready;
   logic [ACC_W-1:0] acc_out;
   logic             overflow;
   logic             busy;

   int n_checks;
   int n_fail;

   product_accumulator #(.N(N), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .product    (product),
      .acc_valid  (acc_valid),
      .acc_ready  (acc_ready),
      .acc_out    (acc_out),
      .overflow   (overflow),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change and outputs are sampled on the falling edge.
   task automatic begin_job(input int n);
      @(negedge clk);
      start = 1'b1;
      len   = LEN_W'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic feed(input int p);
      prod_valid = 1'b1;
      product    = (2*N)'(p);
      @(negedge clk);
      prod_valid = 1'b0;
   endtask

   task automatic accept_result();
      acc_ready = 1'b1;
      @(negedge clk);
      acc_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      n_checks++;
      if (prod_ready !== 1'b0 || acc_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: prod_ready=%b acc_valid=%b busy=%b, required 0 0 0",
                  prod_ready, acc_valid, busy);
      end
      n_checks++;
      if (acc_out !== 12'd0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_acc: acc_out=%0d overflow=%b, required 0 0", acc_out, overflow);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      begin_job(3);
      n_checks++;
      if (prod_ready !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_ready_latency: prod_ready=%b busy=%b, required 1 1", prod_ready, busy);
      end
      feed(15);
      feed(30);
      feed(225);
      n_checks++;
      if (acc_valid !== 1'b1 || prod_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_valid_latency: acc_valid=%b prod_ready=%b, required 1 0", acc_valid, prod_ready);
      end
      n_checks++;
      if (acc_out !== 12'h10E || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_sum: acc_out=%0d overflow=%b, required 270 0", acc_out, overflow);
      end
      accept_result();
      n_checks++;
      if (busy !== 1'b0 || acc_valid !== 1'b0 || acc_out !== 12'd270) begin
         n_fail++;
         $display("FAIL basic_idle: busy=%b acc_valid=%b acc_out=%0d, required 0 0 270",
                  busy, acc_valid, acc_out);
      end
   endtask

   task automatic test_idle_ignore();
      prod_valid = 1'b1;
      product    = 8'd99;
      @(negedge clk);
      @(negedge clk);
      prod_valid = 1'b0;
      n_checks++;
      if (acc_out !== 12'd270 || prod_ready !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_prod_ignored: acc_out=%0d prod_ready=%b busy=%b, required 270 0 0",
                  acc_out, prod_ready, busy);
      end
   endtask

   task automatic test_stalls();
      begin_job(2);
      feed(7);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (prod_ready !== 1'b1 || acc_out !== 12'd7 || acc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_cycle%0d: prod_ready=%b acc_out=%0d acc_valid=%b, required 1 7 0",
                     i, prod_ready, acc_out, acc_valid);
         end
         @(negedge clk);
      end
      feed(9);
      n_checks++;
      if (acc_valid !== 1'b1 || acc_out !== 12'd16) begin
         n_fail++;
         $display("FAIL stall_sum: acc_valid=%b acc_out=%0d, required 1 16", acc_valid, acc_out);
      end
      accept_result();
   endtask

   task automatic test_backpressure();
      begin_job(1);
      feed(100);
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (acc_valid !== 1'b1 || acc_out !== 12'd100 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_cycle%0d: acc_valid=%b acc_out=%0d busy=%b, required 1 100 1",
                     i, acc_valid, acc_out, busy);
         end
         @(negedge clk);
      end
      accept_result();
      n_checks++;
      if (acc_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL backpressure_release: acc_valid=%b busy=%b, required 0 0", acc_valid, busy);
      end
   endtask

   task automatic test_overflow();
      begin_job(19);
      for (int i = 0; i < 19; i++)
         feed(225);
      n_checks++;
      if (acc_valid !== 1'b1 || acc_out !== 12'd179 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_wrap: acc_valid=%b acc_out=%0d overflow=%b, required 1 179 1",
                  acc_valid, acc_out, overflow);
      end
      accept_result();
      n_checks++;
      if (overflow !== 1'b1 || acc_out !== 12'd179) begin
         n_fail++;
         $display("FAIL overflow_idle_hold: acc_out=%0d overflow=%b, required 179 1", acc_out, overflow);
      end
      begin_job(1);
      n_checks++;
      if (overflow !== 1'b0 || acc_out !== 12'd0) begin
         n_fail++;
         $display("FAIL overflow_clear_on_start: acc_out=%0d overflow=%b, required 0 0", acc_out, overflow);
      end
      feed(5);
      n_checks++;
      if (acc_valid !== 1'b1 || acc_out !== 12'd5 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_next_job: acc_valid=%b acc_out=%0d overflow=%b, required 1 5 0",
                  acc_valid, acc_out, overflow);
      end
      accept_result();
   endtask

   task automatic test_zero_len_and_ignored_start();
      begin_job(0);
      n_checks++;
      if (acc_valid !== 1'b1 || acc_out !== 12'd0 || prod_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len: acc_valid=%b acc_out=%0d prod_ready=%b, required 1 0 0",
                  acc_valid, acc_out, prod_ready);
      end
      accept_result();
      begin_job(2);
      start = 1'b1;
      len   = 8'd7;
      feed(10);
      start = 1'b0;
      len   = 8'd0;
      n_checks++;
      if (prod_ready !== 1'b1 || acc_out !== 12'd10) begin
         n_fail++;
         $display("FAIL ignored_start_mid: prod_ready=%b acc_out=%0d, required 1 10", prod_ready, acc_out);
      end
      feed(20);
      n_checks++;
      if (acc_valid !== 1'b1 || acc_out !== 12'd30) begin
         n_fail++;
         $display("FAIL ignored_start_done: acc_valid=%b acc_out=%0d, required 1 30", acc_valid, acc_out);
      end
      accept_result();
   endtask

   task automatic test_reset_mid_job();
      begin_job(4);
      feed(1);
      feed(2);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (prod_ready !== 1'b0 || busy !== 1'b0 || acc_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_flags: prod_ready=%b busy=%b acc_valid=%b, required 0 0 0",
                  prod_ready, busy, acc_valid);
      end
      n_checks++;
      if (acc_out !== 12'd0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_acc: acc_out=%0d overflow=%b, required 0 0", acc_out, overflow);
      end
      @(negedge clk);
      rst = 1'b0;
      begin_job(1);
      feed(3);
      n_checks++;
      if (acc_valid !== 1'b1 || acc_out !== 12'd3) begin
         n_fail++;
         $display("FAIL midreset_fresh_job: acc_valid=%b acc_out=%0d, required 1 3", acc_valid, acc_out);
      end
      accept_result();
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      start      = 1'b0;
      len        = '0;
      prod_valid = 1'b0;
      product    = '0;
      acc_ready  = 1'b0;
      test_reset();
      test_basic();
      test_idle_ignore();
      test_stalls();
      test_backpressure();
      test_overflow();
      test_zero_len_and_ignored_start();
      test_reset_mid_job();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
